// File: rtl/cpu_tick_generator_pkg.sv
// Shared definitions for the CPU tick generator: state encoding, default widths
// and the state decoder used by the top-level FSM.
package cpu_tick_generator_pkg;

    localparam int unsigned DIV_WIDTH_DEF = 16;
    localparam int unsigned CNT_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        TG_IDLE   = 2'd0,
        TG_RUN    = 2'd1,
        TG_HALTED = 2'd2
    } tg_state_e;

    // The spare code 2'd3 is treated as IDLE so a corrupted register recovers safely.
    function automatic tg_state_e decode_state(input logic [1:0] raw);
        case (raw)
            2'd1:    return TG_RUN;
            2'd2:    return TG_HALTED;
            default: return TG_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/cpu_tick_generator_if.sv
// Control/status bundle between an operator or debug master and the tick generator.
interface cpu_tick_generator_if #(
    parameter int DIV_WIDTH = 16,
    parameter int CNT_WIDTH = 32
);
    logic                 Run;
    logic                 Step;
    logic                 Halt;
    logic                 Clear;
    logic [DIV_WIDTH-1:0] Divisor;
    logic                 Tick;
    logic                 Running;
    logic                 Halted;
    logic [CNT_WIDTH-1:0] TickCount;

    modport master (
        output Run, Step, Halt, Clear, Divisor,
        input  Tick, Running, Halted, TickCount
    );

    modport slave (
        input  Run, Step, Halt, Clear, Divisor,
        output Tick, Running, Halted, TickCount
    );
endinterface

// File: rtl/cpu_tick_generator_tick_divider.sv
// Programmable down-counter for free-run mode; Zero flags the cycle a tick is due.
module tick_divider #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Load,
    input  logic                 Enable,
    input  logic [DIV_WIDTH-1:0] Divisor,
    output logic                 Zero
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (Load) begin
            cnt_d = Divisor;
        end else if (Enable) begin
            cnt_d = cnt_q - DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Zero = (cnt_q == '0);

endmodule

// File: rtl/cpu_tick_generator.sv
// Tick strobe generator for the single-cycle core: free-run with divider,
// single-step, halt/clear, registered run/halt status and an issued-tick counter.
module cpu_tick_generator #(
    parameter int DIV_WIDTH = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                   Clock,
    input  logic                   Reset,
    cpu_tick_generator_if.slave    bus
);
    import cpu_tick_generator_pkg::*;

    logic [1:0]           state_q;
    tg_state_e            state;
    tg_state_e            state_d;
    logic                 step_prev_q;
    logic                 tick_q,    tick_d;
    logic                 running_q, running_d;
    logic                 halted_q,  halted_d;
    logic [CNT_WIDTH-1:0] count_q,   count_d;
    logic                 div_load;
    logic                 div_en;
    logic                 div_zero;

    tick_divider #(.DIV_WIDTH(DIV_WIDTH)) u_divider (
        .Clock   (Clock),
        .Reset   (Reset),
        .Load    (div_load),
        .Enable  (div_en),
        .Divisor (bus.Divisor),
        .Zero    (div_zero)
    );

    // NOTE: every signal assigned here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state    = decode_state(state_q);
        state_d  = state;
        tick_d   = 1'b0;
        div_load = 1'b0;
        div_en   = 1'b0;

        if (bus.Halt) begin
            state_d = TG_HALTED;
        end else begin
            case (state)
                TG_HALTED: begin
                    if (bus.Clear) state_d = TG_IDLE;
                end
                TG_RUN: begin
                    if (!bus.Run) begin
                        state_d = TG_IDLE;
                    end else if (div_zero) begin
                        tick_d   = 1'b1;
                        div_load = 1'b1;
                    end else begin
                        div_en = 1'b1;
                    end
                end
                default: begin
                    // Run beats a coincident Step edge; the first tick is immediate.
                    if (bus.Run) begin
                        state_d  = TG_RUN;
                        tick_d   = 1'b1;
                        div_load = 1'b1;
                    end else if (bus.Step && !step_prev_q) begin
                        tick_d = 1'b1;
                    end
                end
            endcase
        end

        if (bus.Clear) begin
            count_d = '0;
        end else if (tick_d) begin
            count_d = count_q + CNT_WIDTH'(1);
        end else begin
            count_d = count_q;
        end

        running_d = (state_d == TG_RUN);
        halted_d  = (state_d == TG_HALTED);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= TG_IDLE;
            step_prev_q <= 1'b0;
            tick_q      <= 1'b0;
            running_q   <= 1'b0;
            halted_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            step_prev_q <= bus.Step;
            tick_q      <= tick_d;
            running_q   <= running_d;
            halted_q    <= halted_d;
            count_q     <= count_d;
        end
    end

    assign bus.Tick      = tick_q;
    assign bus.Running   = running_q;
    assign bus.Halted    = halted_q;
    assign bus.TickCount = count_q;

endmodule

// File: tb/tb_cpu_tick_generator.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// stimulus compared each cycle against a period/phase model of the tick generator.
module tb_cpu_tick_generator;

    logic        clk = 1'b0;
    logic        rst;
    logic        run, step, halt, clear;
    logic [15:0] divisor;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_tick_generator_if #(.DIV_WIDTH(16), .CNT_WIDTH(32)) bus_a ();
    cpu_tick_generator_if #(.DIV_WIDTH(16), .CNT_WIDTH(4))  bus_b ();

    assign bus_a.Run = run;   assign bus_a.Step = step;   assign bus_a.Halt = halt;
    assign bus_a.Clear = clear; assign bus_a.Divisor = divisor;
    assign bus_b.Run = run;   assign bus_b.Step = step;   assign bus_b.Halt = halt;
    assign bus_b.Clear = clear; assign bus_b.Divisor = divisor;

    cpu_tick_generator #(.DIV_WIDTH(16), .CNT_WIDTH(32)) dut_a (
        .Clock (clk), .Reset (rst), .bus (bus_a.slave)
    );
    cpu_tick_generator #(.DIV_WIDTH(16), .CNT_WIDTH(4)) dut_b (
        .Clock (clk), .Reset (rst), .bus (bus_b.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a tick falls due once `since` cycles have elapsed equal to the latched period.
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
    int          m_mode;
    int          m_since, m_period;
    bit          m_tick, m_step_prev;
    logic [31:0] m_count;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = M_IDLE; m_since = 0; m_period = 0;
            m_tick = 0; m_step_prev = 0; m_count = 0;
        end else begin
            bit fire;
            fire = 0;
            if (halt) begin
                m_mode = M_HALT;
            end else if (m_mode == M_HALT) begin
                if (clear) m_mode = M_IDLE;
            end else if (m_mode == M_IDLE) begin
                if (run) begin
                    m_mode = M_RUN; fire = 1; m_since = 0; m_period = int'(divisor);
                end else if (step && !m_step_prev) begin
                    fire = 1;
                end
            end else if (!run) begin
                m_mode = M_IDLE;
            end else if (m_since >= m_period) begin
                fire = 1; m_since = 0; m_period = int'(divisor);
            end else begin
                m_since++;
            end
            m_step_prev = step;
            m_tick      = fire;
            if (clear)     m_count = 0;
            else if (fire) m_count = m_count + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("tick",        bus_a.Tick,      m_tick);
            check("running",     bus_a.Running,   m_mode == M_RUN);
            check("halted",      bus_a.Halted,    m_mode == M_HALT);
            check("count",       bus_a.TickCount, m_count);
            check("count_w4",    bus_b.TickCount, m_count[3:0]);
            check("tick_w4",     bus_b.Tick,      m_tick);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int          ticks;
        int          run_seen;
        logic [12:0] mask;

        rst = 1'b1; run = 0; step = 0; halt = 0; clear = 0; divisor = '0;
        cyc(2);
        check("rst_tick",    bus_a.Tick,      1'b0);
        check("rst_running", bus_a.Running,   1'b0);
        check("rst_halted",  bus_a.Halted,    1'b0);
        check("rst_count",   bus_a.TickCount, 32'd0);
        #2 rst = 1'b0;
        cyc(1);

        // Divisor 0: ten back-to-back ticks, Running falls with Tick.
        divisor = 16'd0; run = 1'b1; ticks = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc(1);
            ticks += int'(bus_a.Tick);
        end
        check("t1_ticks",   ticks,           10);
        check("t1_count",   bus_a.TickCount, 32'd10);
        check("t1_running", bus_a.Running,   1'b1);
        run = 1'b0;
        cyc(1);
        check("t1_tick_off",    bus_a.Tick,      1'b0);
        check("t1_running_off", bus_a.Running,   1'b0);
        check("t1_count_hold",  bus_a.TickCount, 32'd10);

        // Divisor 3: ticks one cycle in four.
        clear = 1'b1;
        cyc(1);
        clear = 1'b0; divisor = 16'd3; run = 1'b1; mask = '0;
        for (int i = 1; i <= 12; i++) begin
            cyc(1);
            mask[i] = bus_a.Tick;
        end
        check("t2_pattern", mask,            13'h222);
        check("t2_count",   bus_a.TickCount, 32'd3);
        run = 1'b0;
        cyc(1);

        // Single-step: held Step gives one tick per rising edge only.
        clear = 1'b1;
        cyc(1);
        clear = 1'b0; step = 1'b1; ticks = 0; run_seen = 0;
        for (int i = 0; i < 5; i++) begin cyc(1); ticks += int'(bus_a.Tick); run_seen += int'(bus_a.Running); end
        step = 1'b0;
        cyc(1); ticks += int'(bus_a.Tick);
        step = 1'b1;
        for (int i = 0; i < 3; i++) begin cyc(1); ticks += int'(bus_a.Tick); run_seen += int'(bus_a.Running); end
        step = 1'b0;
        for (int i = 0; i < 2; i++) begin cyc(1); ticks += int'(bus_a.Tick); end
        check("t3_ticks",   ticks,           2);
        check("t3_running", run_seen,        0);
        check("t3_count",   bus_a.TickCount, 32'd2);

        // Halt from RUN, persistence, release by Clear while Run stays high.
        divisor = 16'd0; run = 1'b1;
        cyc(3);
        halt = 1'b1;
        cyc(1);
        check("t4_halt_tick",   bus_a.Tick,   1'b0);
        check("t4_halted",      bus_a.Halted, 1'b1);
        halt = 1'b0;
        cyc(3);
        check("t4_still_halted", bus_a.Halted, 1'b1);
        check("t4_still_quiet",  bus_a.Tick,   1'b0);
        clear = 1'b1;
        cyc(1);
        check("t4_clr_halted",  bus_a.Halted,    1'b0);
        check("t4_clr_running", bus_a.Running,   1'b0);
        check("t4_clr_count",   bus_a.TickCount, 32'd0);
        clear = 1'b0;
        cyc(1);
        check("t4_rerun_tick",  bus_a.Tick,      1'b1);
        check("t4_rerun_count", bus_a.TickCount, 32'd1);

        // Divisor change mid-count only takes effect at the next reload.
        run = 1'b0;
        cyc(1);
        divisor = 16'd2; run = 1'b1; mask = '0;
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            mask[i] = bus_a.Tick;
            if (i == 2) divisor = 16'd0;
        end
        check("t5_pattern", mask, 13'h1F2);

        // Asynchronous reset mid-run, then restart.
        #2 rst = 1'b1;
        #1;
        check("t5_rst_tick",    bus_a.Tick,      1'b0);
        check("t5_rst_running", bus_a.Running,   1'b0);
        check("t5_rst_count",   bus_a.TickCount, 32'd0);
        cyc(1);
        #2 rst = 1'b0;
        cyc(1);
        check("t5_restart_tick",  bus_a.Tick,      1'b1);
        check("t5_restart_count", bus_a.TickCount, 32'd1);

        // Narrow counter wraps after 16 ticks.
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        cyc(17);
        check("t6_count_w32", bus_a.TickCount, 32'd17);
        check("t6_count_w4",  bus_b.TickCount, 4'd1);

        // Randomised phase.
        for (int i = 0; i < 3000; i++) begin
            halt  = ($urandom_range(0, 99) < 4);
            clear = ($urandom_range(0, 99) < 8);
            step  = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 6)  run = ~run;
            if ($urandom_range(0, 99) < 10) divisor = 16'($urandom_range(0, 4));
            cyc(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
